// File: rtl/mux_sel_arbiter_pkg.sv
// Shared widths, FSM encoding and helpers for the round-robin mux-select arbiter.
package arb_pkg;

  localparam int N_CH  = 8;
  localparam int SEL_W = $clog2(N_CH);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  function automatic logic [N_CH-1:0] to_onehot(input logic [SEL_W-1:0] idx);
    return N_CH'(1) << idx;
  endfunction

endpackage

// File: rtl/mux_sel_arbiter_if.sv
// Request/grant bundle between the requesting sources and the arbiter.
interface mux_sel_arbiter_if;
  import arb_pkg::*;

  logic [N_CH-1:0]  req;
  logic             release_i;
  logic [SEL_W-1:0] sel;
  logic             grant_valid;
  logic [N_CH-1:0]  grant_onehot;

  // master = requesting side, slave = arbiter
  modport master (output req, output release_i,
                  input  sel, input  grant_valid, input grant_onehot);
  modport slave  (input  req, input  release_i,
                  output sel, output grant_valid, output grant_onehot);
endinterface

// File: rtl/mux_sel_arbiter_rr_pick.sv
// Combinational round-robin pick: first set bit of req at or after ptr, wrapping.
module rr_pick
  import arb_pkg::*;
(
  input  logic [N_CH-1:0]  req_i,
  input  logic [SEL_W-1:0] ptr_i,
  output logic             found_o,
  output logic [SEL_W-1:0] idx_o
);

  logic [2*N_CH-1:0] req_dbl;
  logic [N_CH-1:0]   req_rot;
  logic [SEL_W-1:0]  rot_idx;

  // Rotating the doubled vector puts channel ptr at bit 0.
  assign req_dbl = {req_i, req_i} >> ptr_i;
  assign req_rot = req_dbl[N_CH-1:0];

  always_comb begin
    // NOTE: every output of a combinational block gets a default first, or a latch is inferred.
    rot_idx = '0;
    found_o = 1'b0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (req_rot[i]) begin
        rot_idx = SEL_W'(i);
        found_o = 1'b1;
      end
    end
  end

  assign idx_o = rot_idx + ptr_i;

endmodule

// File: rtl/mux_sel_arbiter.sv
// Round-robin arbiter producing a registered, grant-stable select for the 8:1 data mux.
module mux_sel_arbiter
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  mux_sel_arbiter_if.slave   bus
);

  localparam int HOLD_W = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);

  arb_state_e        state_q;
  logic [SEL_W-1:0]  sel_q;
  logic [SEL_W-1:0]  ptr_q;
  logic [HOLD_W-1:0] hold_cnt_q;
  logic              grant_valid_q;
  logic [N_CH-1:0]   grant_onehot_q;

  logic [SEL_W-1:0]  pick_ptr_d;
  logic [SEL_W-1:0]  ptr_d;
  logic [HOLD_W-1:0] hold_inc_d;
  logic              pick_found;
  logic [SEL_W-1:0]  pick_idx;
  logic              hold_hit;
  logic              grant_end;

  assign hold_hit  = (MAX_HOLD != 0) && (hold_cnt_q == HOLD_LAST);
  assign grant_end = bus.release_i || !bus.req[sel_q] || hold_hit;
  assign ptr_d     = sel_q + SEL_W'(1);

  // While granted the search already starts after the owner, so a still-requesting
  // owner ranks last and a dropped one is absent from req anyway.
  assign pick_ptr_d = (state_q == GRANT) ? ptr_d : ptr_q;
  assign hold_inc_d = (&hold_cnt_q) ? hold_cnt_q : hold_cnt_q + HOLD_W'(1);

  rr_pick u_pick (
    .req_i   (bus.req),
    .ptr_i   (pick_ptr_d),
    .found_o (pick_found),
    .idx_o   (pick_idx)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      sel_q          <= '0;
      ptr_q          <= '0;
      hold_cnt_q     <= '0;
      grant_valid_q  <= 1'b0;
      grant_onehot_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pick_found) begin
            state_q        <= GRANT;
            sel_q          <= pick_idx;
            hold_cnt_q     <= '0;
            grant_valid_q  <= 1'b1;
            grant_onehot_q <= to_onehot(pick_idx);
          end
        end
        GRANT: begin
          if (grant_end) begin
            ptr_q      <= ptr_d;
            hold_cnt_q <= '0;
            if (pick_found) begin
              sel_q          <= pick_idx;
              grant_onehot_q <= to_onehot(pick_idx);
            end else begin
              state_q        <= IDLE;
              grant_valid_q  <= 1'b0;
              grant_onehot_q <= '0;
            end
          end else begin
            hold_cnt_q <= hold_inc_d;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.sel          = sel_q;
  assign bus.grant_valid  = grant_valid_q;
  assign bus.grant_onehot = grant_onehot_q;

endmodule

// File: tb/tb_mux_sel_arbiter.sv
// Directed, table-driven bench for mux_sel_arbiter with MAX_HOLD=4.
module tb_mux_sel_arbiter;
  import arb_pkg::*;

  typedef struct {
    logic       rst_n;
    logic [7:0] req;
    logic       rel;
    logic [2:0] sel;
    logic       valid;
    logic [7:0] oh;
  } vec_t;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_bad;
  vec_t tab_a[$];
  vec_t tab_b[$];

  mux_sel_arbiter_if bus ();

  mux_sel_arbiter #(.MAX_HOLD(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic r, input logic [7:0] q, input logic l,
                              input logic [2:0] s, input logic v, input logic [7:0] o);
    vec_t t;
    t.rst_n = r; t.req = q; t.rel = l; t.sel = s; t.valid = v; t.oh = o;
    return t;
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_step(input logic r, input logic [7:0] q, input logic l);
    rst_n         = r;
    bus.req       = q;
    bus.release_i = l;
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input logic [2:0] s, input logic v, input logic [7:0] o);
    check({tag, ".sel"},   8'(bus.sel),         8'(s));
    check({tag, ".valid"}, 8'(bus.grant_valid), 8'(v));
    check({tag, ".oh"},    bus.grant_onehot,    o);
  endtask

  task automatic apply_vec(input string tag, input vec_t t);
    drive_step(t.rst_n, t.req, t.rel);
    check_out(tag, t.sel, t.valid, t.oh);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0;
    bus.req = 8'hFF;
    bus.release_i = 1'b0;

    // reset with all requests high, then single request grant and release to IDLE
    tab_a.push_back(mk(1'b0, 8'hFF, 1'b0, 3'd0, 1'b0, 8'h00));
    tab_a.push_back(mk(1'b0, 8'hFF, 1'b0, 3'd0, 1'b0, 8'h00));
    tab_a.push_back(mk(1'b1, 8'h04, 1'b0, 3'd2, 1'b1, 8'h04));
    tab_a.push_back(mk(1'b1, 8'h00, 1'b1, 3'd2, 1'b0, 8'h00));
    tab_a.push_back(mk(1'b1, 8'h00, 1'b0, 3'd2, 1'b0, 8'h00));
    tab_a.push_back(mk(1'b0, 8'h00, 1'b0, 3'd0, 1'b0, 8'h00));

    // drop+release handover, release handover, non-owner noise, reset mid-grant, hold limit
    tab_b.push_back(mk(1'b0, 8'h00, 1'b0, 3'd0, 1'b0, 8'h00));
    tab_b.push_back(mk(1'b1, 8'h28, 1'b0, 3'd3, 1'b1, 8'h08));
    tab_b.push_back(mk(1'b1, 8'h20, 1'b1, 3'd5, 1'b1, 8'h20));
    tab_b.push_back(mk(1'b1, 8'h20, 1'b0, 3'd5, 1'b1, 8'h20));
    tab_b.push_back(mk(1'b1, 8'h21, 1'b1, 3'd0, 1'b1, 8'h01));
    tab_b.push_back(mk(1'b1, 8'h23, 1'b0, 3'd0, 1'b1, 8'h01));
    tab_b.push_back(mk(1'b1, 8'h00, 1'b0, 3'd0, 1'b0, 8'h00));
    tab_b.push_back(mk(1'b1, 8'h40, 1'b0, 3'd6, 1'b1, 8'h40));
    tab_b.push_back(mk(1'b0, 8'h40, 1'b0, 3'd0, 1'b0, 8'h00));
    tab_b.push_back(mk(1'b1, 8'h41, 1'b0, 3'd0, 1'b1, 8'h01));
    tab_b.push_back(mk(1'b1, 8'h41, 1'b0, 3'd0, 1'b1, 8'h01));
    tab_b.push_back(mk(1'b1, 8'h41, 1'b0, 3'd0, 1'b1, 8'h01));
    tab_b.push_back(mk(1'b1, 8'h41, 1'b0, 3'd0, 1'b1, 8'h01));
    tab_b.push_back(mk(1'b1, 8'h41, 1'b0, 3'd6, 1'b1, 8'h40));
    tab_b.push_back(mk(1'b1, 8'h00, 1'b0, 3'd6, 1'b0, 8'h00));

    for (int i = 0; i < tab_a.size(); i++)
      apply_vec($sformatf("a%0d", i), tab_a[i]);

    // all channels requesting: four cycles each, wrapping 7 -> 0, never dropping
    for (int k = 0; k < 36; k++) begin
      logic [2:0] s;
      s = 3'((k / 4) % 8);
      drive_step(1'b1, 8'hFF, 1'b0);
      check_out($sformatf("rr%0d", k), s, 1'b1, 8'(1) << s);
    end
    drive_step(1'b1, 8'h00, 1'b0);
    check_out("rr_drop", 3'd0, 1'b0, 8'h00);

    // lone requester at the hold limit keeps being re-granted
    for (int k = 0; k < 12; k++) begin
      drive_step(1'b1, 8'h80, 1'b0);
      check_out($sformatf("lone%0d", k), 3'd7, 1'b1, 8'h80);
    end

    for (int i = 0; i < tab_b.size(); i++)
      apply_vec($sformatf("b%0d", i), tab_b[i]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
